// File: rtl/and_packet_packer.sv
// Packs a valid-only word stream into AMOUNT_OF_PACKET-word packets and buffers them in a
// small circular queue with a valid/ready output; packets arriving to a full queue are dropped.
module and_packet_packer #(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned AMOUNT_OF_PACKET = 4,
  parameter int unsigned DEPTH            = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              valid_in,
  input  logic                              flush,
  output logic [WIDTH*AMOUNT_OF_PACKET-1:0] packet_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic                              overflow_o,
  output logic [7:0]                        drop_cnt_o,
  output logic [3:0]                        level_o
);

  localparam int unsigned PktW = WIDTH * AMOUNT_OF_PACKET;
  localparam int unsigned CntW = 5;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [PktW-1:0] asm_q, asm_d;
  logic            push;

  logic [PktW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      count_q, count_d;
  logic            valid_q, valid_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            pop, full, accept, drop;

  // Assembly: asm_d already carries the arriving word, so a push stores the complete packet.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    push       = 1'b0;
    if (flush) begin
      state_d    = StIdle;
      word_cnt_d = '0;
    end else if (valid_in) begin
      for (int i = 0; i < AMOUNT_OF_PACKET; i++) begin
        if (word_cnt_q == CntW'(i)) asm_d[i*WIDTH +: WIDTH] = data_in;
      end
      if (word_cnt_q == CntW'(AMOUNT_OF_PACKET - 1)) begin
        push       = 1'b1;
        word_cnt_d = '0;
        state_d    = StIdle;
      end else begin
        word_cnt_d = word_cnt_q + CntW'(1);
        state_d    = StFill;
      end
    end
  end

  // A pop in the same cycle frees the head slot, so a push to a full queue still fits.
  always_comb begin
    pop    = valid_q && ready_i;
    full   = (count_q == 4'(DEPTH));
    accept = push && (!full || pop);
    drop   = push && full && !pop;

    wr_ptr_d = wr_ptr_q;
    if (accept) wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);

    count_d    = count_q + {3'b000, accept} - {3'b000, pop};
    valid_d    = (count_d != 4'd0);
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      if (accept) mem_q[wr_ptr_q] <= asm_d;
    end
  end

  assign packet_o   = mem_q[rd_ptr_q];
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign level_o    = count_q;

endmodule

// File: tb/tb_and_packet_packer.sv
// Directed bench for and_packet_packer: expected packets are queued as words are driven and
// compared by a monitor whenever the DUT hands a packet over (valid_o && ready_i).
module tb_and_packet_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        flush;
  logic [31:0] packet_o;
  logic        valid_o;
  logic        ready_i;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;
  logic [3:0]  level_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pkt;

  and_packet_packer #(
    .WIDTH           (8),
    .AMOUNT_OF_PACKET(4),
    .DEPTH           (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .flush     (flush),
    .packet_o  (packet_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o),
    .level_o   (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after a rising edge and held for one full cycle.
  task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
    valid_in = v;
    data_in  = d;
    flush    = f;
    ready_i  = r;
    @(posedge clk);
    #1;
  endtask

  // Handshake is decided at the next rising edge; inputs and outputs are stable at negedge.
  always @(negedge clk) begin
    if (rst && valid_o && ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_packet observed=%h expected=none", packet_o);
      end else begin
        exp_pkt = sb.pop_front();
        assert (packet_o === exp_pkt) else begin
          errors++;
          $error("FAIL packet_order observed=%h expected=%h", packet_o, exp_pkt);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    valid_in = 1'b0; data_in = '0; flush = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_packet", packet_o, 32'd0);
    chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
    chk("rst_level", {28'd0, level_o}, 32'd0);
    rst = 1'b1;

    // 1: single packet, visible one cycle after its last word
    drive(1, 8'h11, 0, 1);
    drive(1, 8'h22, 0, 1);
    drive(1, 8'h33, 0, 1);
    sb.push_back(32'h44332211);
    drive(1, 8'h44, 0, 1);
    chk("t1_valid", {31'd0, valid_o}, 32'd1);
    chk("t1_level", {28'd0, level_o}, 32'd1);
    chk("t1_packet", packet_o, 32'h44332211);
    drive(0, 8'h00, 0, 1);
    chk("t1_valid_after", {31'd0, valid_o}, 32'd0);
    chk("t1_level_after", {28'd0, level_o}, 32'd0);

    // 2: fill with ready low, third packet dropped
    sb.push_back(32'h04030201);
    sb.push_back(32'h08070605);
    for (int i = 1; i <= 12; i++) drive(1, 8'(i), 0, 0);
    chk("t2_level", {28'd0, level_o}, 32'd2);
    chk("t2_overflow", {31'd0, overflow_o}, 32'd1);
    chk("t2_drop", {24'd0, drop_cnt_o}, 32'd1);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);
    chk("t2_valid_after", {31'd0, valid_o}, 32'd0);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: full queue, pop coincides with the completing word
    sb.push_back(32'h04030201);
    sb.push_back(32'h08070605);
    for (int i = 1; i <= 11; i++) drive(1, 8'(i), 0, 0);
    sb.push_back(32'h0C0B0A09);
    drive(1, 8'h0C, 0, 1);
    chk("t3_level", {28'd0, level_o}, 32'd2);
    chk("t3_drop", {24'd0, drop_cnt_o}, 32'd1);
    chk("t3_head", packet_o, 32'h08070605);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);
    chk("t3_level_after", {28'd0, level_o}, 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: flush discards partial packet, including a completing word flushed in the same cycle
    drive(1, 8'hAA, 0, 1);
    drive(1, 8'hBB, 0, 1);
    drive(0, 8'h00, 1, 1);
    drive(1, 8'h01, 0, 1);
    drive(1, 8'h02, 0, 1);
    drive(1, 8'h03, 0, 1);
    sb.push_back(32'h04030201);
    drive(1, 8'h04, 0, 1);
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h05, 0, 1);
    drive(1, 8'h06, 0, 1);
    drive(1, 8'h07, 0, 1);
    drive(1, 8'h08, 1, 1);
    drive(0, 8'h00, 0, 1);
    chk("t4_flush_valid", {31'd0, valid_o}, 32'd0);
    chk("t4_flush_level", {28'd0, level_o}, 32'd0);
    sb.push_back(32'h24232221);
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h21 + i), 0, 1);
    drive(0, 8'h00, 0, 1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: reset mid-packet with one packet queued discards everything
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h31 + i), 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h35 + i), 0, 0);
    chk("t5_pre_level", {28'd0, level_o}, 32'd1);
    rst = 1'b0;
    drive(0, 8'h00, 0, 0);
    rst = 1'b1;
    sb.delete();
    chk("t5_valid", {31'd0, valid_o}, 32'd0);
    chk("t5_level", {28'd0, level_o}, 32'd0);
    chk("t5_overflow", {31'd0, overflow_o}, 32'd0);
    chk("t5_drop", {24'd0, drop_cnt_o}, 32'd0);
    sb.push_back(32'h13121110);
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h10 + i), 0, 1);
    drive(0, 8'h00, 0, 1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: drop counter saturates
    for (int p = 0; p < 302; p++) begin
      logic [31:0] pkt;
      for (int k = 0; k < 4; k++) pkt[k*8 +: 8] = 8'(p * 4 + k);
      if (p < 2) sb.push_back(pkt);
      for (int k = 0; k < 4; k++) drive(1, pkt[k*8 +: 8], 0, 0);
    end
    chk("t6_drop_sat", {24'd0, drop_cnt_o}, 32'd255);
    chk("t6_overflow", {31'd0, overflow_o}, 32'd1);
    chk("t6_level", {28'd0, level_o}, 32'd2);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);
    chk("t6_valid_after", {31'd0, valid_o}, 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/and_packet_packer.md
Name: and_packet_packer

Overview:
- Sits directly downstream of the dual-FIFO AND stage.
- Consumes its unthrottled stream of WIDTH-bit AND results (valid-only, no backpressure) and groups every AMOUNT_OF_PACKET consecutive words into one wide packet.
- Buffers completed packets in a small circular queue and presents them on a valid/ready output interface.
- Counts and flags packets lost when the queue overflows.

Parameters:
- WIDTH, 8, bits per input word (matches the upstream AND result width).
- AMOUNT_OF_PACKET, 4, words per packet; legal range 2..16.
- DEPTH, 2, packet queue entries; legal range 1..8.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low: state clears on a rising clk edge while rst==0.
- data_in  input  WIDTH  AND-result word from the upstream stage.
- valid_in  input  1  data_in is valid this cycle; no ready path; every valid word must be taken.
- flush  input  1  discards the partially assembled packet; does not touch the queue.
- packet_o  output  WIDTH*AMOUNT_OF_PACKET  head packet; word 0 (first received) in bits [WIDTH-1:0].
- valid_o  output  1  packet_o holds a packet.
- ready_i  input  1  downstream accepts packet_o when valid_o&&ready_i.
- overflow_o  output  1  sticky: at least one packet dropped since reset.
- drop_cnt_o  output  8  number of dropped packets, saturating at 255.
- level_o  output  4  number of occupied queue entries, 0..DEPTH.

Behaviour:
- Reset (rst==0 at a clk edge):
  - word_cnt=0; the assembly register is zeroed; queue wr_ptr, rd_ptr and count are 0.
  - Outputs: valid_o=0, packet_o=0, overflow_o=0, drop_cnt_o=0, level_o=0.
  - Reset mid-packet or with a full queue discards everything; nothing is emitted afterwards.
- Assembly FSM, two states:
  - IDLE (word_cnt==0):
    - valid_in: store the word in slot 0, word_cnt=1, go to FILL.
  - FILL (0<word_cnt<AMOUNT_OF_PACKET):
    - valid_in: store the word in slot word_cnt and increment word_cnt.
    - The word that completes the packet raises an internal push, sets word_cnt=0 and returns to IDLE.
  - No valid_in: hold state.
- flush:
  - Forces IDLE and word_cnt=0.
  - If flush and valid_in occur in the same cycle, the word is discarded, including a word that would complete a packet.
  - Completed packets already in the queue are unaffected.
- Queue (circular buffer, DEPTH entries):
  - Pop when valid_o&&ready_i.
  - Push writes the assembled packet: all slots, including the word arriving this cycle.
  - The queue is full when count==DEPTH.
  - Push with queue not full: accepted, count+1.
  - Push while full with no pop this cycle: packet dropped, overflow_o=1 (sticky), drop_cnt_o+1 saturating at 255, count and contents unchanged.
  - Push while full with a pop this cycle: the pop frees a slot, the push is accepted, count unchanged, no drop.
  - Push and pop with 0<count<DEPTH: count unchanged.
  - Pointers wrap from DEPTH-1 to 0.
- Output:
  - valid_o = (count!=0), registered.
  - packet_o = queue[rd_ptr], stable while valid_o&&!ready_i.
  - ready_i is ignored when valid_o==0.
- Latency: the packet becomes visible on valid_o/packet_o in the cycle after the clk edge that accepts its last word, when the queue was empty.
- Throughput: back-to-back packets at one word per clock with ready_i held high cause no loss for any DEPTH>=1.
- level_o = count.

Test Plan:
1. Reset, then valid_in for 4 cycles with data 0x11,0x22,0x33,0x44, ready_i=1 -> one cycle later valid_o=1 with packet_o=0x44332211; it pops next cycle; valid_o=0, level_o=0.
2. ready_i=0, 12 consecutive words 0x01..0x0C -> packets 0x04030201 and 0x08070605 are queued (level_o=2); the third packet is dropped (overflow_o=1, drop_cnt_o=1). Then raise ready_i -> 0x04030201 then 0x08070605 on successive cycles; valid_o=0 after.
3. Queue full, ready_i pulsed high in the same cycle the last word of a third packet 0x0C0B0A09 arrives -> no drop (drop_cnt_o unchanged), level_o stays 2, the queue ends holding 0x08070605 then 0x0C0B0A09.
4. Two words 0xAA,0xBB, then flush, then 0x01,0x02,0x03,0x04 -> single packet 0x04030201; 0xAA and 0xBB never appear.
5. Assert rst=0 for one clk edge after 3 words of a packet with one packet queued -> valid_o=0, level_o=0, overflow_o=0. The next 4 words 0x10..0x13 yield packet 0x13121110.
6. 300 dropped packets with ready_i=0 and DEPTH=2 -> drop_cnt_o saturates at 255, overflow_o remains 1.
